// File: rtl/clk_speed_classifier_if.sv
// Bus-clock speed classifier interface.
// The bus side (master) drives the synchronised bus-clock level and its
// rising-edge pulse. The classifier (slave) returns the confirmed speed class,
// the status flags and the last accepted period sample.
interface clk_speed_classifier_if #(
  parameter int PERIOD_MAX = 64
) ();
  localparam int W = $clog2(PERIOD_MAX + 1);

  logic         CLK_BUS;
  logic         CLK_BUS_EN;
  logic [1:0]   SPEED;
  logic         VALID;
  logic         FAST;
  logic         CHANGE;
  logic [W-1:0] PERIOD;

  modport master (
    output CLK_BUS, CLK_BUS_EN,
    input  SPEED, VALID, FAST, CHANGE, PERIOD
  );

  modport slave (
    input  CLK_BUS, CLK_BUS_EN,
    output SPEED, VALID, FAST, CHANGE, PERIOD
  );
endinterface

// File: rtl/clk_speed_classifier.sv
// Cartridge-slot bus clock speed classifier.
// Measures the bus-clock period in CLK cycles and sorts it into four classes:
// stopped (0), normal 3.58 MHz (1), 1.5x (2) and 2x (3). A class has to be
// seen CONFIRM times in a row before SPEED moves to it. A missing bus clock
// (counter saturating at PERIOD_MAX) drops SPEED to 0 at once.
// Optional build macro CLK_SPEED_GLITCH_FILTER_EN: discards edges whose
// period is below GLITCH_TH, and edges seen while CLK_BUS is low.
module clk_speed_classifier #(
  parameter int PERIOD_MAX = 64,
  parameter int TH_MID     = 25,
  parameter int TH_FAST    = 17,
  parameter int CONFIRM    = 2,
  parameter int GLITCH_TH  = 6
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  clk_speed_classifier_if.slave bus
);

  localparam int W  = $clog2(PERIOD_MAX + 1);
  localparam int AW = $clog2(CONFIRM + 1);

  localparam logic [W-1:0]  C_MAX     = W'(PERIOD_MAX);
  localparam logic [W-1:0]  C_MID     = W'(TH_MID);
  localparam logic [W-1:0]  C_FAST    = W'(TH_FAST);
  localparam logic [AW-1:0] C_CONFIRM = AW'(CONFIRM);

  typedef enum logic {
    ST_IDLE,
    ST_ARMED
  } state_t;

  typedef enum logic [1:0] {
    SPD_STOPPED = 2'd0,
    SPD_NORMAL  = 2'd1,
    SPD_MID     = 2'd2,
    SPD_FAST    = 2'd3
  } speed_t;

  // Maps a period sample to its speed class.
  function automatic speed_t classify(input logic [W-1:0] p);
    if (p >= C_MAX)       return SPD_STOPPED;
    else if (p >= C_MID)  return SPD_NORMAL;
    else if (p >= C_FAST) return SPD_MID;
    else                  return SPD_FAST;
  endfunction

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_cnt;
  logic [W-1:0]  w_cnt_next;
  logic [AW-1:0] r_agree;
  logic [AW-1:0] w_agree_next;
  speed_t        r_last;
  speed_t        w_last_next;
  speed_t        r_speed;
  speed_t        w_speed_next;
  logic          r_valid;
  logic          w_valid_next;
  logic          r_fast;
  logic          r_change;
  logic          w_change_next;
  logic [W-1:0]  r_period;
  logic [W-1:0]  w_period_next;

  logic          w_armed;
  logic          w_en;
  logic          w_sample;
  logic          w_stop;
  speed_t        w_cand;

  assign w_armed = (r_state == ST_ARMED);

`ifdef CLK_SPEED_GLITCH_FILTER_EN
  // An edge counts only with the bus clock high and, once armed, only when
  // the gap since the last accepted edge is long enough to be real.
  assign w_en = bus.CLK_BUS_EN && bus.CLK_BUS && !(w_armed && (r_cnt < W'(GLITCH_TH)));
`else
  // Every edge counts; the level and the glitch threshold are not used here.
  logic w_unused_ok;
  assign w_unused_ok = bus.CLK_BUS ^ GLITCH_TH[0];
  assign w_en        = bus.CLK_BUS_EN;
`endif

  // An accepted edge while armed yields a sample; an accepted edge wins over
  // saturation, so stop detection only fires when no edge arrives.
  assign w_sample = w_en && w_armed;
  assign w_stop   = !w_en && w_armed && (r_cnt == C_MAX);
  assign w_cand   = classify(r_cnt);

  // Arming FSM state register.
  always_ff @(posedge CLK or negedge RESET_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!RESET_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Arming FSM next state: any accepted edge arms, a stop event disarms.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_state_next = r_state;
    if (w_en)        w_state_next = ST_ARMED;
    else if (w_stop) w_state_next = ST_IDLE;
  end

  // Period counter: restart at 1 on an accepted edge, otherwise count up and hold at PERIOD_MAX.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_en)               w_cnt_next = W'(1);
    else if (r_cnt != C_MAX) w_cnt_next = r_cnt + W'(1);
  end

  // Confirmation, speed update and stop handling.
  always_comb begin
    w_agree_next  = r_agree;
    w_last_next   = r_last;
    w_speed_next  = r_speed;
    w_valid_next  = r_valid;
    w_change_next = 1'b0;
    w_period_next = r_period;
    if (w_sample) begin
      w_period_next = r_cnt;
      if (w_cand == r_last) begin
        if (r_agree != C_CONFIRM) w_agree_next = r_agree + AW'(1);
      end else begin
        w_agree_next = AW'(1);
        w_last_next  = w_cand;
      end
      if (w_agree_next == C_CONFIRM) begin
        w_valid_next = 1'b1;
        if (w_cand != r_speed) begin
          w_speed_next  = w_cand;
          w_change_next = 1'b1;
        end
      end
    end else if (w_stop) begin
      w_speed_next  = SPD_STOPPED;
      w_valid_next  = 1'b0;
      w_agree_next  = '0;
      w_change_next = (r_speed != SPD_STOPPED);
    end
  end

  // Datapath and output registers; FAST follows the next SPEED on the same edge.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_cnt    <= '0;
      r_agree  <= '0;
      r_last   <= SPD_STOPPED;
      r_speed  <= SPD_STOPPED;
      r_valid  <= 1'b0;
      r_fast   <= 1'b0;
      r_change <= 1'b0;
      r_period <= '0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_agree  <= w_agree_next;
      r_last   <= w_last_next;
      r_speed  <= w_speed_next;
      r_valid  <= w_valid_next;
      r_fast   <= (w_speed_next >= SPD_MID);
      r_change <= w_change_next;
      r_period <= w_period_next;
    end
  end

  assign bus.SPEED  = r_speed;
  assign bus.VALID  = r_valid;
  assign bus.FAST   = r_fast;
  assign bus.CHANGE = r_change;
  assign bus.PERIOD = r_period;

endmodule
